bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter; the inverse of the binary-to-BCD path that feeds the 7-segment display.
- Accepts a packed BCD word on a start strobe.
- Converts it most-significant digit first, one digit per clock (acc = acc*10 + digit).
- Presents the binary result with a one-cycle valid pulse.
- Used where display-format values (e.g. entered digits) must be turned back into counter values.

---
 rtl/bcd_to_bin.sv | 91 +++++++++
 tb/tb_bcd_to_bin.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, most-significant digit first, one digit per clock.
// Result and o_valid land DIGITS cycles after the accepting edge; starts are ignored while o_busy is high.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CNT_W  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_BCD,
  output logic [BIN_W-1:0]      o_bin,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state;
  logic [4*DIGITS-1:0]  shift_reg;
  logic [BIN_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 err;

  logic [3:0]           digit;
  logic                 digit_bad;
  logic                 err_next;
  logic [BIN_W-1:0]     acc_next;
  logic                 last_digit;

  always_comb begin
    digit      = shift_reg[4*DIGITS-1 -: 4];
    digit_bad  = (digit > 4'd9);
    err_next   = err | digit_bad;
    // Illegal digits still enter the accumulator; the result is discarded on error.
    acc_next   = acc * BIN_W'(10) + BIN_W'(digit);
    last_digit = (cnt == CNT_W'(DIGITS - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      o_bin     <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            shift_reg <= i_BCD;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            o_busy    <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          acc       <= acc_next;
          shift_reg <= shift_reg << 4;
          cnt       <= cnt + CNT_W'(1);
          err       <= err_next;
          if (last_digit) begin
            o_bin   <= err_next ? '0 : acc_next;
            o_err   <= err_next;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed plus randomized checks of bcd_to_bin against a positional-arithmetic reference model.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int CNT_W  = 3;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_start;
  logic [4*DIGITS-1:0]  i_BCD;
  logic [BIN_W-1:0]     o_bin;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_err;

  int checks = 0;
  int errors = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_BCD   (i_BCD),
    .o_bin   (o_bin),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Value of a packed BCD word as sum of digit * 10^position; any nibble above 9 flags an error.
  function automatic int model_bin(input logic [4*DIGITS-1:0] bcd, output bit bad);
    int value  = 0;
    int weight = 1;
    int d;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((bcd >> (4 * i)) & 'hF);
      if (d > 9) bad = 1'b1;
      value  += d * weight;
      weight *= 10;
    end
    return bad ? 0 : value;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One full conversion with cycle-exact checks of busy/valid and the model's result.
  task automatic do_conv(input logic [4*DIGITS-1:0] bcd);
    int  exp_bin;
    bit  exp_err;
    exp_bin = model_bin(bcd, exp_err);
    i_BCD   = bcd;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_BCD   = 16'($urandom);
    chk("accept_busy", int'(o_busy), 1);
    chk("accept_valid", int'(o_valid), 0);
    for (int c = 1; c < DIGITS; c++) begin
      step();
      chk("conv_valid", int'(o_valid), 0);
      chk("conv_busy", int'(o_busy), 1);
    end
    step();
    chk("done_valid", int'(o_valid), 1);
    chk("done_bin", int'(o_bin), exp_bin);
    chk("done_err", int'(o_err), int'(exp_err));
    chk("done_busy", int'(o_busy), 1);
    step();
    chk("post_valid", int'(o_valid), 0);
    chk("post_busy", int'(o_busy), 0);
    chk("post_bin_hold", int'(o_bin), exp_bin);
  endtask

  initial begin
    logic [4*DIGITS-1:0] directed [7];
    logic [4*DIGITS-1:0] rnd;
    int                  vcount;
    int                  vidx [$];
    int                  vbin [$];
    int                  verr [$];

    directed = '{16'h0001, 16'h0034, 16'h0529, 16'h1024, 16'h2222, 16'h0000, 16'h9999};

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_BCD   = '0;
    step();
    chk("rst_bin", int'(o_bin), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_err", int'(o_err), 0);
    i_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_outputs", int'({o_bin, o_valid, o_busy, o_err}), 0);
    end

    foreach (directed[i]) do_conv(directed[i]);

    do_conv(16'h12A4);
    do_conv(16'hF000);
    do_conv(16'h0042);

    for (int n = 0; n < 30; n++) begin
      rnd = '0;
      for (int d = 0; d < DIGITS; d++) rnd[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rnd[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      do_conv(rnd);
    end

    // Start held high with input changing mid-conversion: only IDLE accepts.
    i_BCD   = 16'h1234;
    i_start = 1'b1;
    step();
    i_BCD = 16'h9999;
    vidx.delete(); vbin.delete(); verr.delete();
    for (int c = 1; c <= 12; c++) begin
      step();
      if (o_valid) begin
        vidx.push_back(c);
        vbin.push_back(int'(o_bin));
        verr.push_back(int'(o_err));
      end
    end
    i_start = 1'b0;
    chk("hold_valid_count", vidx.size(), 2);
    if (vidx.size() == 2) begin
      chk("hold_first_idx", vidx[0], DIGITS);
      chk("hold_first_bin", vbin[0], 1234);
      chk_range("hold_second_idx", vidx[1], 2*DIGITS + 1, 2*DIGITS + 2);
      chk("hold_second_bin", vbin[1], 9999);
      chk("hold_second_err", verr[1], 0);
    end
    for (int c = 0; c < 8; c++) step();
    chk("hold_drain_busy", int'(o_busy), 0);

    // Mid-conversion reset abandons the conversion.
    i_BCD   = 16'h0777;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    chk("midrst_outputs", int'({o_bin, o_valid, o_busy, o_err}), 0);
    i_rst  = 1'b0;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (o_valid || o_busy) vcount++;
    end
    chk("midrst_quiet", vcount, 0);
    do_conv(16'h0015);

    // Reset together with start: reset wins.
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_BCD   = 16'h0005;
    step();
    i_rst   = 1'b0;
    i_start = 1'b0;
    chk("rst_start_busy", int'(o_busy), 0);
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (o_valid || o_busy) vcount++;
    end
    chk("rst_start_quiet", vcount, 0);
    chk("rst_start_bin", int'(o_bin), 0);

    // Back-to-back with start held high continuously.
    i_BCD   = 16'h0100;
    i_start = 1'b1;
    vidx.delete(); vbin.delete(); verr.delete();
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_valid) begin
        vidx.push_back(c);
        vbin.push_back(int'(o_bin));
        verr.push_back(int'(o_err));
      end
    end
    i_start = 1'b0;
    chk_range("b2b_count", vidx.size(), 6, 8);
    foreach (vidx[i]) begin
      chk("b2b_bin", vbin[i], 100);
      chk("b2b_err", verr[i], 0);
      if (i > 0) chk_range("b2b_gap", vidx[i] - vidx[i-1], DIGITS + 1, DIGITS + 2);
    end
    for (int c = 0; c < 8; c++) step();
    chk("final_idle", int'({o_valid, o_busy}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
